cp0_intc: RTL and testbench

//  Parametrised coprocessor-0 with an interrupt controller, the successor to the single-level CP0.
//  - Holds Count(9), Compare(11), Status(12), Cause(13) and EPC(14).
//  - Arbitrates synchronous traps (syscall/break/teq) against N_INT masked hardware interrupts plus a Count/Compare timer.
//  - Supports nested entry through a Status mask stack.
//  - Supplies the trap redirect (EXC_TAKEN/HANDLER_PC) to the single-cycle/pipelined CPU fetch stage.

---
 rtl/cp0_pkg.sv | 35 +++
 rtl/cp0_timer.sv | 38 +++
 rtl/cp0_intc.sv | 133 +++++++++++++
 tb/tb_cp0_intc.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cp0_pkg.sv
// rtl/cp0_pkg.sv - CP0 register indices, cause codes, Status bit positions and shared types
package cp0_pkg;

    localparam logic [4:0] CP0_COUNT   = 5'd9;
    localparam logic [4:0] CP0_COMPARE = 5'd11;
    localparam logic [4:0] CP0_STATUS  = 5'd12;
    localparam logic [4:0] CP0_CAUSE   = 5'd13;
    localparam logic [4:0] CP0_EPC     = 5'd14;

    localparam logic [4:0] EXC_INT = 5'h00;
    localparam logic [4:0] EXC_SYS = 5'h08;
    localparam logic [4:0] EXC_BP  = 5'h09;
    localparam logic [4:0] EXC_TEQ = 5'h0d;

    localparam int ST_IE     = 0;
    localparam int ST_EN_SYS = 1;
    localparam int ST_EN_BP  = 2;
    localparam int ST_EN_TEQ = 3;

    localparam logic [31:0] STATUS_RST = 32'h0000_FF0F;
    localparam logic [2:0]  DEPTH_MAX  = 3'd6;

    typedef enum logic {S_RUN, S_HANDLER} cp0_state_e;

    // Per-cause enable bit in Status; unknown codes are never enabled.
    function automatic logic trap_enabled(input logic [31:0] status, input logic [4:0] code);
        case (code)
            EXC_SYS: return status[ST_EN_SYS];
            EXC_BP:  return status[ST_EN_BP];
            EXC_TEQ: return status[ST_EN_TEQ];
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/cp0_timer.sv
// rtl/cp0_timer.sv - free-running Count, Compare and sticky Count==Compare interrupt flag
module cp0_timer (
    input  logic        CLK,
    input  logic        RST,
    input  logic        i_count_we,
    input  logic        i_compare_we,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_count,
    output logic [31:0] o_compare,
    output logic        o_timer_int
);

    logic [31:0] r_count;
    logic [31:0] r_compare;
    logic        r_timer_int;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_count     <= '0;
            r_compare   <= '0;
            r_timer_int <= 1'b0;
        end else begin
            r_count <= i_count_we ? i_wdata : r_count + 32'd1;
            if (i_compare_we)
                r_compare <= i_wdata;
            // Writing Compare acknowledges the timer even on a same-cycle match.
            if (i_compare_we)
                r_timer_int <= 1'b0;
            else if (r_count == r_compare && r_compare != 32'd0)
                r_timer_int <= 1'b1;
        end
    end

    assign o_count     = r_count;
    assign o_compare   = r_compare;
    assign o_timer_int = r_timer_int;

endmodule

// File: rtl/cp0_intc.sv
// rtl/cp0_intc.sv - coprocessor 0 with trap/interrupt arbitration and nested Status mask stack
module cp0_intc
    import cp0_pkg::*;
#(
    parameter int          N_INT       = 6,
    parameter logic [31:0] HANDLER_PC0 = 32'h0040_0004,
    parameter logic [31:0] EPC_ADJ     = 32'h4,
    parameter int          STK_SH      = 5
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             MFC0,
    input  logic             MTC0,
    input  logic [4:0]       RDC,
    input  logic [31:0]      DATA_IN,
    input  logic [31:0]      PC,
    input  logic             EXC_REQ,
    input  logic [4:0]       EXC_CODE,
    input  logic             ERET,
    input  logic [N_INT-1:0] INT_IN,
    output logic [31:0]      DATA_OUT,
    output logic [31:0]      STATUS,
    output logic [31:0]      EPC_OUT,
    output logic             EXC_TAKEN,
    output logic [31:0]      HANDLER_PC,
    output logic             TIMER_INT
);

    cp0_state_e  r_state, w_state_next;
    logic [2:0]  r_depth;
    logic [31:0] r_status;
    logic [31:0] r_epc;
    logic [4:0]  r_cause_code;
    logic [1:0]  r_sw_ip;
    logic        r_exc_taken;

    logic [31:0] w_count, w_compare;
    logic        w_timer_int;
    logic [6:0]  w_int_ext;
    logic [7:0]  w_ip;
    logic        w_trap_ok, w_int_req, w_take, w_eret_ok, w_wr_en;
    logic [31:0] w_rdata;

    assign w_int_ext = {{(7 - N_INT){1'b0}}, INT_IN};
    // Software-written IP[1:0] stays pending until software clears it.
    assign w_ip      = {w_timer_int, w_int_ext[6:2], w_int_ext[1:0] | r_sw_ip};

    assign w_trap_ok = EXC_REQ & r_status[ST_IE] & trap_enabled(r_status, EXC_CODE);
    assign w_int_req = r_status[ST_IE] & |(w_ip & r_status[15:8]);
    assign w_take    = w_trap_ok | w_int_req;
    assign w_eret_ok = ERET & (r_state == S_HANDLER) & ~w_take;
    assign w_wr_en   = MTC0 & ~w_take & ~w_eret_ok;

    cp0_timer u_timer (
        .CLK          (CLK),
        .RST          (RST),
        .i_count_we   (w_wr_en && RDC == CP0_COUNT),
        .i_compare_we (w_wr_en && RDC == CP0_COMPARE),
        .i_wdata      (DATA_IN),
        .o_count      (w_count),
        .o_compare    (w_compare),
        .o_timer_int  (w_timer_int)
    );

    always_ff @(posedge CLK) begin
        if (RST)
            r_state <= S_RUN;
        else
            r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_RUN:     if (w_take) w_state_next = S_HANDLER;
            S_HANDLER: if (w_eret_ok && r_depth == 3'd1) w_state_next = S_RUN;
            default:   w_state_next = S_RUN;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_status     <= STATUS_RST;
            r_epc        <= '0;
            r_cause_code <= '0;
            r_sw_ip      <= '0;
            r_depth      <= '0;
            r_exc_taken  <= 1'b0;
        end else begin
            r_exc_taken <= w_take;
            if (w_take) begin
                // Shifting Status pushes the current IE/enables/IM one level up the stack.
                r_status     <= r_status << STK_SH;
                r_cause_code <= w_trap_ok ? EXC_CODE : EXC_INT;
                r_epc        <= w_trap_ok ? PC - EPC_ADJ : PC;
                if (r_depth != DEPTH_MAX)
                    r_depth <= r_depth + 3'd1;
            end else if (w_eret_ok) begin
                r_status <= r_status >> STK_SH;
                r_depth  <= r_depth - 3'd1;
            end else if (w_wr_en) begin
                case (RDC)
                    CP0_STATUS: r_status <= DATA_IN;
                    CP0_CAUSE:  r_sw_ip  <= DATA_IN[9:8];
                    CP0_EPC:    r_epc    <= DATA_IN;
                    default:    ;
                endcase
            end
        end
    end

    always_comb begin
        w_rdata = '0;
        if (MFC0) begin
            case (RDC)
                CP0_COUNT:   w_rdata = w_count;
                CP0_COMPARE: w_rdata = w_compare;
                CP0_STATUS:  w_rdata = r_status;
                CP0_CAUSE:   w_rdata = {16'h0, w_ip, 1'b0, r_cause_code, 2'b00};
                CP0_EPC:     w_rdata = r_epc;
                default:     w_rdata = '0;
            endcase
        end
    end

    assign DATA_OUT   = w_rdata;
    assign STATUS     = r_status;
    assign EPC_OUT    = r_epc;
    assign EXC_TAKEN  = r_exc_taken;
    assign HANDLER_PC = HANDLER_PC0;
    assign TIMER_INT  = w_timer_int;

endmodule

// File: tb/tb_cp0_intc.sv
// tb/tb_cp0_intc.sv - directed and randomized checks of cp0_intc against a behavioural model
module tb_cp0_intc;

    localparam int N_INT = 6;

    logic             CLK = 1'b0;
    logic             RST, MFC0, MTC0, EXC_REQ, ERET;
    logic [4:0]       RDC, EXC_CODE;
    logic [31:0]      DATA_IN, PC;
    logic [N_INT-1:0] INT_IN;
    logic [31:0]      DATA_OUT, STATUS, EPC_OUT, HANDLER_PC;
    logic             EXC_TAKEN, TIMER_INT;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] m_status, m_epc, m_count, m_compare;
    logic [4:0]  m_code;
    logic [1:0]  m_sw;
    logic        m_timer, m_taken;
    int          m_depth;

    cp0_intc #(.N_INT(N_INT)) dut (
        .CLK(CLK), .RST(RST), .MFC0(MFC0), .MTC0(MTC0), .RDC(RDC), .DATA_IN(DATA_IN),
        .PC(PC), .EXC_REQ(EXC_REQ), .EXC_CODE(EXC_CODE), .ERET(ERET), .INT_IN(INT_IN),
        .DATA_OUT(DATA_OUT), .STATUS(STATUS), .EPC_OUT(EPC_OUT), .EXC_TAKEN(EXC_TAKEN),
        .HANDLER_PC(HANDLER_PC), .TIMER_INT(TIMER_INT)
    );

    always #5 CLK = ~CLK;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_status = 32'h0000_FF0F;
        m_epc = 0; m_count = 0; m_compare = 0;
        m_code = 0; m_sw = 0; m_timer = 0; m_taken = 0; m_depth = 0;
    endtask

    function automatic logic [7:0] m_ip();
        return {m_timer, 1'b0, INT_IN} | {6'b0, m_sw};
    endfunction

    function automatic logic [31:0] m_read();
        if (!MFC0) return 32'h0;
        case (RDC)
            5'd9:    return m_count;
            5'd11:   return m_compare;
            5'd12:   return m_status;
            5'd13:   return (32'(m_ip()) << 8) + (32'(m_code) << 2);
            5'd14:   return m_epc;
            default: return 32'h0;
        endcase
    endfunction

    // Applies one clock's worth of the architectural rules to the model.
    task automatic model_step();
        logic [7:0] ip;
        bit ie, en, trap, intr, take, eret_ok, wr;
        if (RST) begin
            model_reset();
            return;
        end
        ip = m_ip();
        ie = m_status[0];
        case (EXC_CODE)
            5'h08:   en = m_status[1];
            5'h09:   en = m_status[2];
            5'h0d:   en = m_status[3];
            default: en = 0;
        endcase
        trap    = EXC_REQ && ie && en;
        intr    = ie && ((ip & m_status[15:8]) != 0);
        take    = trap || intr;
        eret_ok = !take && ERET && m_depth > 0;
        wr      = MTC0 && !take && !eret_ok;
        if (wr && RDC == 5'd11) m_timer = 0;
        else if (m_count == m_compare && m_compare != 0) m_timer = 1;
        m_count = (wr && RDC == 5'd9) ? DATA_IN : m_count + 1;
        if (wr && RDC == 5'd11) m_compare = DATA_IN;
        m_taken = take;
        if (take) begin
            m_status = m_status * 32;
            m_code   = trap ? EXC_CODE : 5'h00;
            m_epc    = trap ? PC - 32'd4 : PC;
            if (m_depth < 6) m_depth++;
        end else if (eret_ok) begin
            m_status = m_status / 32;
            m_depth--;
        end else if (wr) begin
            case (RDC)
                5'd12:   m_status = DATA_IN;
                5'd13:   m_sw = DATA_IN[9:8];
                5'd14:   m_epc = DATA_IN;
                default: ;
            endcase
        end
    endtask

    task automatic idle();
        RST = 0; MFC0 = 0; MTC0 = 0; RDC = 0; DATA_IN = 0; PC = 32'h0040_0000;
        EXC_REQ = 0; EXC_CODE = 0; ERET = 0; INT_IN = '0;
    endtask

    // Inputs are set just after a falling edge; this runs one full clock and compares.
    task automatic cycle();
        #1;
        check_eq("rdata", DATA_OUT, m_read());
        @(posedge CLK);
        model_step();
        @(negedge CLK);
        check_eq("status", STATUS, m_status);
        check_eq("epc", EPC_OUT, m_epc);
        check_eq("taken", {31'b0, EXC_TAKEN}, {31'b0, m_taken});
        check_eq("timer", {31'b0, TIMER_INT}, {31'b0, m_timer});
    endtask

    task automatic mtc0(input logic [4:0] idx, input logic [31:0] val);
        idle(); MTC0 = 1; RDC = idx; DATA_IN = val;
        cycle();
    endtask

    task automatic trap(input logic [4:0] code, input logic [31:0] pc);
        idle(); EXC_REQ = 1; EXC_CODE = code; PC = pc;
        cycle();
    endtask

    task automatic eret();
        idle(); ERET = 1;
        cycle();
    endtask

    initial begin
        idle();
        RST = 1;
        @(posedge CLK);
        model_reset();
        @(negedge CLK);

        // Reset state
        idle(); MFC0 = 1; RDC = 5'd12;
        #1;
        check_eq("t1_rd_status", DATA_OUT, 32'h0000_FF0F);
        check_eq("t1_status", STATUS, 32'h0000_FF0F);
        check_eq("t1_taken", {31'b0, EXC_TAKEN}, 32'h0);
        check_eq("t1_handler_pc", HANDLER_PC, 32'h0040_0004);
        cycle();

        // Syscall entry and return
        trap(5'h08, 32'h0040_0040);
        check_eq("t2_taken", {31'b0, EXC_TAKEN}, 32'h1);
        check_eq("t2_epc", EPC_OUT, 32'h0040_003C);
        check_eq("t2_status", STATUS, 32'h001F_E1E0);
        idle(); MFC0 = 1; RDC = 5'd13;
        #1;
        check_eq("t2_cause_code", {27'b0, DATA_OUT[6:2]}, 32'h8);
        eret();
        check_eq("t2_eret_status", STATUS, 32'h0000_FF0F);
        check_eq("t2_pulse_end", {31'b0, EXC_TAKEN}, 32'h0);

        // Disabled syscall ignored; trap beats same-cycle interrupt
        mtc0(5'd12, 32'h0000_FF0D);
        trap(5'h08, 32'h0040_0060);
        check_eq("t3_no_take", {31'b0, EXC_TAKEN}, 32'h0);
        idle(); EXC_REQ = 1; EXC_CODE = 5'h09; INT_IN = 6'b000100; PC = 32'h0040_0080;
        cycle();
        check_eq("t3_taken", {31'b0, EXC_TAKEN}, 32'h1);
        check_eq("t3_epc", EPC_OUT, 32'h0040_007C);
        idle(); MFC0 = 1; RDC = 5'd13;
        #1;
        check_eq("t3_cause_code", {27'b0, DATA_OUT[6:2]}, 32'h9);
        eret();
        check_eq("t3_eret_status", STATUS, 32'h0000_FF0D);
        mtc0(5'd12, 32'h0000_FF0F);

        // Timer interrupt
        mtc0(5'd11, 32'd20);
        mtc0(5'd9, 32'd10);
        idle();
        for (int i = 0; i < 10; i++) cycle();
        check_eq("t4_timer_pre", {31'b0, TIMER_INT}, 32'h0);
        cycle();
        check_eq("t4_timer_set", {31'b0, TIMER_INT}, 32'h1);
        idle(); MFC0 = 1; RDC = 5'd9; PC = 32'h0040_0100;
        #1;
        check_eq("t4_count", DATA_OUT, 32'd21);
        cycle();
        check_eq("t4_int_taken", {31'b0, EXC_TAKEN}, 32'h1);
        check_eq("t4_int_epc", EPC_OUT, 32'h0040_0100);
        idle(); MFC0 = 1; RDC = 5'd13;
        #1;
        check_eq("t4_cause_code", {27'b0, DATA_OUT[6:2]}, 32'h0);
        check_eq("t4_cause_ip7", {31'b0, DATA_OUT[15]}, 32'h1);
        mtc0(5'd11, 32'd0);
        check_eq("t4_timer_clr", {31'b0, TIMER_INT}, 32'h0);
        eret();
        check_eq("t4_eret_status", STATUS, 32'h0000_FF0F);

        // Nested entry
        trap(5'h08, 32'h0040_0200);
        mtc0(5'd12, 32'h001F_E1EF);
        trap(5'h09, 32'h0040_0300);
        check_eq("t5_nest_taken", {31'b0, EXC_TAKEN}, 32'h1);
        check_eq("t5_nest_status", STATUS, 32'h03FC_3DE0);
        eret();
        check_eq("t5_eret1", STATUS, 32'h001F_E1EF);
        eret();
        check_eq("t5_eret2", STATUS, 32'h0000_FF0F);
        eret();
        check_eq("t5_eret3", STATUS, 32'h0000_FF0F);

        // Reset while in handler, with a simultaneous write
        trap(5'h0d, 32'h0040_0400);
        check_eq("t6_teq_taken", {31'b0, EXC_TAKEN}, 32'h1);
        idle(); RST = 1; MTC0 = 1; RDC = 5'd12; DATA_IN = 32'h1234_5678;
        cycle();
        check_eq("t6_status", STATUS, 32'h0000_FF0F);
        check_eq("t6_epc", EPC_OUT, 32'h0);
        check_eq("t6_taken", {31'b0, EXC_TAKEN}, 32'h0);
        eret();
        check_eq("t6_eret_noop", STATUS, 32'h0000_FF0F);

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            idle();
            RST  = ($urandom_range(0, 63) == 0);
            MFC0 = $urandom_range(0, 1);
            case ($urandom_range(0, 6))
                0: RDC = 5'd9;  1: RDC = 5'd11; 2: RDC = 5'd12;
                3: RDC = 5'd13; 4: RDC = 5'd14; 5: RDC = 5'd0;
                default: RDC = 5'($urandom);
            endcase
            MTC0 = ($urandom_range(0, 4) == 0);
            case (RDC)
                5'd11:   DATA_IN = m_count + $urandom_range(1, 30);
                5'd12:   DATA_IN = $urandom_range(0, 1) ? (32'h0000_FF0F | ($urandom & 32'h00FF_0000)) : $urandom;
                default: DATA_IN = $urandom;
            endcase
            PC       = $urandom & 32'hFFFF_FFFC;
            EXC_REQ  = ($urandom_range(0, 7) == 0);
            case ($urandom_range(0, 3))
                0: EXC_CODE = 5'h08; 1: EXC_CODE = 5'h09; 2: EXC_CODE = 5'h0d;
                default: EXC_CODE = 5'($urandom);
            endcase
            ERET   = ($urandom_range(0, 4) == 0);
            INT_IN = ($urandom_range(0, 9) == 0) ? N_INT'($urandom) : '0;
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
